kv_arbiter: RTL

- Round-robin arbiter that shares one keyvalue store slave port between NREQ Wishbone-style requesters.
- Sequences each transaction on the slave side: present request, wait for ACK, drop STB, wait for ACK to clear.
- Returns read data and DUP to the winning requester.
- Times out lookups that never ACK (read misses) and pulses the store's abort input so the store returns to idle.

---
 rtl/kv_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/kv_arbiter.sv
// Round-robin arbiter sharing one key/value store slave port between NREQ requesters.
// Sequences issue / wait-for-ack / release on the slave side and times out unanswered lookups.
module kv_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 7,
  parameter int DW      = 7,
  parameter int TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_stb_i,
  input  logic [NREQ-1:0]   req_we_i,
  input  logic [NREQ-1:0]   req_adr_is_key_i,
  input  logic [NREQ-1:0]   req_dat_is_key_i,
  input  logic [NREQ*AW-1:0] req_adr_i,
  input  logic [NREQ*DW-1:0] req_dat_i,
  output logic [NREQ-1:0]   req_ack_o,
  output logic [NREQ-1:0]   req_err_o,
  output logic [DW-1:0]     req_dat_o,
  output logic              req_dup_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              kv_stb_o,
  output logic              kv_cyc_o,
  output logic              kv_we_o,
  output logic              kv_adr_is_key_o,
  output logic              kv_dat_is_key_o,
  output logic [AW-1:0]     kv_adr_o,
  output logic [DW-1:0]     kv_dat_o,
  output logic              kv_abort_o,
  input  logic              kv_ack_i,
  input  logic              kv_dup_i,
  input  logic [DW-1:0]     kv_dat_i,
  input  logic              kv_stall_i
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gidx_q;
  logic [CW-1:0]     cnt_q;
  logic              rel_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   err_q;
  logic [DW-1:0]     rdat_q;
  logic              dup_q;
  logic              stb_q;
  logic              we_q;
  logic              ak_q;
  logic              dk_q;
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     dat_q;
  logic              abort_q;

  logic              win_vld_d;
  logic [PW-1:0]     win_idx_d;
  logic [PW-1:0]     ptr_d;
  logic [PW1-1:0]    cand;

  // Scan requesters starting at the pointer, wrapping modulo NREQ; first hit wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + PW1'(k);
      if (cand >= PW1'(NREQ)) cand = cand - PW1'(NREQ);
      if (!win_vld_d && req_stb_i[cand[PW-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand[PW-1:0];
      end
    end
  end

  assign ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdat_q  <= '0;
      dup_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      ak_q    <= 1'b0;
      dk_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            gidx_q  <= win_idx_d;
            grant_q <= NREQ'(1) << win_idx_d;
            we_q    <= req_we_i[win_idx_d];
            ak_q    <= req_adr_is_key_i[win_idx_d];
            dk_q    <= req_dat_is_key_i[win_idx_d];
            adr_q   <= req_adr_i[win_idx_d*AW +: AW];
            dat_q   <= req_dat_i[win_idx_d*DW +: DW];
            stb_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Stall holds the request here without touching the timeout counter.
          if (!kv_stall_i) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (kv_ack_i) begin
            rdat_q  <= kv_dat_i;
            dup_q   <= kv_dup_i;
            ack_q   <= grant_q;
            stb_q   <= 1'b0;
            rel_q   <= 1'b0;
            state_q <= RELEASE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdat_q  <= '0;
            dup_q   <= 1'b0;
            err_q   <= grant_q;
            abort_q <= 1'b1;
            stb_q   <= 1'b0;
            rel_q   <= 1'b0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          // Two cycles minimum lets the store leave its idle/abort state before the next issue.
          if (rel_q && !kv_ack_i) begin
            grant_q <= '0;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rel_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack_o       = ack_q;
  assign req_err_o       = err_q;
  assign req_dat_o       = rdat_q;
  assign req_dup_o       = dup_q;
  assign grant_o         = grant_q;
  assign kv_stb_o        = stb_q;
  assign kv_cyc_o        = stb_q;
  assign kv_we_o         = we_q;
  assign kv_adr_is_key_o = ak_q;
  assign kv_dat_is_key_o = dk_q;
  assign kv_adr_o        = adr_q;
  assign kv_dat_o        = dat_q;
  assign kv_abort_o      = abort_q;

endmodule
